// File: rtl/kissp_mem_pkg.sv
// Shared definitions for the kissp word-memory controller.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (see kissp_mem_ctrl.sv).
package kissp_mem_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 1024;

  // Index width for a power-of-two depth; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One response at the default word width: read data (0 for write acks)
  // plus the out-of-range flag.
  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] rdata;
    logic                      err;
  } rsp_t;

endpackage

// File: rtl/kissp_mem_ctrl_if.sv
// Request/response bus between a processor port and kissp_mem_ctrl.
// master = requester (processor side), slave = memory controller.
interface kissp_mem_ctrl_if
  import kissp_mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/kissp_rsp_fifo.sv
// Response queue for kissp_mem_ctrl: circular buffer with head-of-queue
// output. Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module kissp_rsp_fifo
  import kissp_mem_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_DATA_W + 1,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Upstream credits keep the queue from overflowing; the guards only make
  // the block safe in isolation.
  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop  && (count_q != '0);

  // Entry storage.
  // NOTE: storage arrays carry no reset; only the pointers and count define
  // which entries are meaningful, and resetting RAM would block inference.
  always_ff @(posedge clk) begin
    if (do_push) begin
      // NOTE: non-blocking assignments for all clocked state, so every
      // register samples pre-edge values regardless of statement order.
      slots[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = slots[rd_ptr_q];

endmodule

// File: rtl/kissp_mem_ctrl.sv
// Parametrised word memory with valid/ready request and response channels,
// byte write enables, a fixed LATENCY read pipeline and a credit-limited
// response queue. Responses leave strictly in request order.
// Optional feature macro: MEM_BOUNDS_CHECK_EN -- when defined, requests with
// req_addr >= DEPTH are flagged with rsp_err=1, return 0 and never write.
// When undefined, the index is the low address bits and addresses wrap.
module kissp_mem_ctrl
  import kissp_mem_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  kissp_mem_ctrl_if.slave  bus
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam int RSP_W = DATA_W + 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  // Same layout as kissp_mem_pkg::rsp_t, at this instance's word width.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_w_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic               accept;
  logic               pop;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  rsp_w_t             stage0;
  logic [LATENCY-1:0] pipe_valid;
  rsp_w_t             pipe_data [LATENCY];
  logic [CNT_W-1:0]   used_q;
  logic [CNT_W-1:0]   fifo_count;
  rsp_w_t             head;
  logic               rsp_valid;

  assign idx = bus.req_addr[IDX_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  assign in_range    = (bus.req_addr < ADDR_W'(DEPTH));
  assign bus.rsp_err = rsp_valid && head.err;
`else
  // Upper address bits are ignored so addresses wrap modulo DEPTH.
  logic unused_addr_bits;
  logic unused_head_err;
  assign unused_addr_bits = ^bus.req_addr;
  assign unused_head_err  = head.err;
  assign in_range         = 1'b1;
  assign bus.rsp_err      = 1'b0;
`endif

  // Credits: used_q counts every accepted request not yet popped, i.e.
  // pipeline entries plus queue entries. Ready depends on registered state
  // only, never on req_valid or rsp_ready.
  assign bus.req_ready = !rst && (used_q < CNT_W'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;

  assign rsp_valid     = !rst && (fifo_count != '0);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_valid ? head.rdata : '0;
  assign pop           = rsp_valid && bus.rsp_ready;

  // Byte-enabled array write at the accept edge; out-of-range writes dropped.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (accept && bus.req_we && in_range && bus.req_be[b]) begin
        mem[idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
      end
    end
  end

  // Response payload formed from the array as it stands before this edge.
  always_comb begin
    // NOTE: default every field first so no path leaves a value held,
    // which would otherwise infer a latch.
    stage0 = '0;
    if (!bus.req_we && in_range) begin
      stage0.rdata = mem[idx];
    end
    stage0.err = !in_range;
  end

  // Valid shift pipeline; reset discards all in-flight requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
      end
    end
  end

  // Payload shift pipeline; qualified by pipe_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_data[0] <= stage0;
    end
    for (int s = 1; s < LATENCY; s++) begin
      pipe_data[s] <= pipe_data[s-1];
    end
  end

  // Outstanding-request counter backing the credit check.
  always_ff @(posedge clk) begin
    if (rst) begin
      used_q <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   used_q <= used_q + CNT_W'(1);
        2'b01:   used_q <= used_q - CNT_W'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  kissp_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_valid[LATENCY-1]),
    .push_data (pipe_data[LATENCY-1]),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head)
  );

endmodule

// File: tb/tb_kissp_mem_ctrl.sv
// Self-checking bench for kissp_mem_ctrl (default parameters). A reference
// model tracks memory contents and the ordered list of outstanding responses;
// a monitor checks credits, response timing and data every cycle.
module tb_kissp_mem_ctrl;
  import kissp_mem_pkg::*;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 1024;
  localparam int ADDR_W    = 32;
  localparam int LATENCY   = 2;
  localparam int RSP_DEPTH = 4;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  kissp_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  kissp_mem_ctrl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .LATENCY   (LATENCY),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    rsp_t rsp;
    bit   known;
    int   ready;
  } exp_t;

  exp_t        exp_q [$];
  rsp_t        popped [$];
  logic [31:0] mdl [DEPTH];
  bit          known [DEPTH];
  logic [31:0] pref [32];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          n_acc    = 0;
  bit          armed    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
  endtask

  task automatic send(input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    bit acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.req_ready;
      tick();
    end
    check("send_accept", 32'(acc), 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // Cycle counter used for response-timing expectations.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor and reference model, evaluated mid-cycle.
  initial forever begin
    exp_t e;
    int   idx;
    bit   in_rng;
    bit   ev;
    @(negedge clk);
    if (rst) begin
      armed = 1'b1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
      exp_q.delete();
    end else if (armed) begin
      check("req_ready", 32'(bus.req_ready), 32'(exp_q.size() < RSP_DEPTH));
      ev = (exp_q.size() > 0) && (cyc >= exp_q[0].ready);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
      if (bus.rsp_valid !== 1'b1) begin
        check("empty_rdata", bus.rsp_rdata, 32'd0);
        check("empty_err",   32'(bus.rsp_err), 32'd0);
      end else if (ev && bus.rsp_ready) begin
        e = exp_q.pop_front();
        if (e.known) check("rsp_rdata", bus.rsp_rdata, e.rsp.rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(e.rsp.err));
        popped.push_back('{rdata: bus.rsp_rdata, err: bus.rsp_err});
      end
      if (bus.req_valid && bus.req_ready) begin
        idx     = int'(bus.req_addr % DEPTH);
        in_rng  = !BOUNDS || (bus.req_addr < DEPTH);
        e.ready = cyc + 1 + LATENCY;
        e.rsp.err = !in_rng;
        n_acc++;
        if (bus.req_we) begin
          if (in_rng) begin
            for (int b = 0; b < 4; b++)
              if (bus.req_be[b]) mdl[idx][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
            if (bus.req_be == 4'hf) known[idx] = 1'b1;
          end
          e.rsp.rdata = '0;
          e.known     = 1'b1;
        end else begin
          e.rsp.rdata = in_rng ? mdl[idx] : 32'd0;
          e.known     = in_rng ? known[idx] : 1'b1;
        end
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int next;
    int n0;
    idle();
    bus.rsp_ready = 1'b1;

    // Reset held for three cycles, then ready on the first cycle after.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.req_ready), 32'd1);
    tick();

    // Prefill the low words used throughout.
    for (int a = 0; a < 32; a++) begin
      pref[a] = $urandom;
      send(1'b1, 32'(a), pref[a], 4'hf);
    end
    drain();

    // Write then read back on the next cycle.
    popped.delete();
    send(1'b1, 32'd5, 32'hDEADBEEF, 4'hf);
    send(1'b0, 32'd5, 32'd0, 4'h0);
    drain();
    check("wr_rd_count", 32'(popped.size()), 32'd2);
    check("wr_ack_rdata", popped[0].rdata, 32'd0);
    check("rd_after_wr", popped[1].rdata, 32'hDEADBEEF);
    pref[5] = 32'hDEADBEEF;

    // Byte enables.
    popped.delete();
    send(1'b1, 32'd7, 32'h11223344, 4'hf);
    send(1'b1, 32'd7, 32'hAABBCCDD, 4'b0101);
    send(1'b0, 32'd7, 32'd0, 4'h0);
    drain();
    check("be_merge", popped[2].rdata, 32'h11BB33DD);
    pref[7] = 32'h11BB33DD;

    // Backpressure: exactly RSP_DEPTH accepts, then resume one per pop.
    popped.delete();
    bus.rsp_ready = 1'b0;
    n0 = n_acc;
    next = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.req_addr = 32'(next);
      @(negedge clk);
      if (bus.req_ready) next++;
      tick();
    end
    check("bp_accepts", 32'(n_acc - n0), 32'd4);
    check("bp_stalled", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 100 && next < 10; i++) begin
      bus.req_addr = 32'(next);
      @(negedge clk);
      if (bus.req_ready) next++;
      tick();
    end
    idle();
    drain();
    check("bp_total", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("bp_order%0d", i), popped[i].rdata, pref[i]);

    // Address wrap / bounds check.
    popped.delete();
    send(1'b1, 32'd1029, 32'h5A, 4'hf);
    send(1'b0, 32'd5, 32'd0, 4'h0);
    drain();
`ifdef MEM_BOUNDS_CHECK_EN
    check("oob_wr_err", 32'(popped[0].err), 32'd1);
    check("oob_wr_rdata", popped[0].rdata, 32'd0);
    check("oob_keeps_old", popped[1].rdata, pref[5]);
`else
    check("wrap_wr_err", 32'(popped[0].err), 32'd0);
    check("wrap_rd", popped[1].rdata, 32'h5A);
    pref[5] = 32'h5A;
`endif

    // Reset with three reads in flight: none of them may surface.
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'd1, 32'd0, 4'h0);
    send(1'b0, 32'd2, 32'd0, 4'h0);
    send(1'b0, 32'd3, 32'd0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    popped.delete();
    bus.rsp_ready = 1'b1;
    repeat (10) tick();
    check("no_stale_rsp", 32'(popped.size()), 32'd0);
    send(1'b0, 32'd2, 32'd0, 4'h0);
    drain();
    check("post_rst_rd", popped[0].rdata, pref[2]);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) bus.req_addr |= 32'($urandom_range(1, 7)) << 10;
      bus.req_wdata = $urandom;
      bus.req_be    = 4'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
